// File: rtl/adder_pkg.sv
// Shared types for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder2.sv
// Single-bit full adder slice used by the serial controller.
// Purely combinational; the carry is held outside this cell.
module full_adder2 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller around one full_adder2 slice.
// Operands are shifted LSB-first; the result is captured on DONE entry.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit, c_bit;
  logic             last, accept;

  full_adder2 u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c    (c_q),
    .sum  (s_bit),
    .carry(c_bit)
  );

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign accept = start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Subtract is a + ~b + 1: invert B on load and force carry-in.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (accept) begin
      a_d   = a;
      b_d   = op_sub ? ~b : b;
      c_d   = op_sub ? 1'b1 : cin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      r_d   = {s_bit, r_q[WIDTH-1:1]};
      c_d   = c_bit;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        sum_d  = {s_bit, r_q[WIDTH-1:1]};
        cout_d = c_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
